rcv_controller: RTL
===================

# rcv_controller

Receive-side sequencer for a UART-style serial link. It detects a start bit and times each bit period with an internal counter. It issues one-cycle shift strobes to an external LSB-first serial-to-parallel shift register, then validates the stop bit. It loads the captured byte into an output buffer with ready, framing-error and overrun status, and sits between the line synchronizer and the consuming FIFO/bus logic.

## Interface
Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit; legal range ≥ 4.
- DATA_BITS, 8, data bits per frame (excludes start and stop bits).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- serial_in  in  1  synchronized serial line, idle high
- sr_parallel  in  DATA_BITS+1  parallel output of the external shift register; bit DATA_BITS is the stop bit, bits DATA_BITS-1:0 are data
- shift_enable  out  1  one-cycle strobe to the shift register
- data_read  in  1  consumer acknowledge of rx_data
- rx_data  out  DATA_BITS  last accepted byte
- data_ready  out  1  rx_data holds an unread byte
- framing_error  out  1  last frame had stop bit = 0
- overrun_error  out  1  a byte was overwritten before being read
- busy  out  1  frame reception in progress

## Operation
- Reset values (rst high at a rising edge): state IDLE, all counters 0, edge register = 1, shift_enable/rx_data/data_ready/framing_error/overrun_error/busy = 0.
- Edge register samples serial_in every cycle. A start edge means serial_in == 0 while the edge register == 1. A start edge is acted on only in IDLE.
- FSM states: IDLE, START_CHK, SHIFT, STOP_CHK, LOAD.
- IDLE: on start edge, go to START_CHK, clear the bit-period counter and clear framing_error.
- START_CHK: wait floor(CLKS_PER_BIT/2) cycles, then sample serial_in.
  - If 0, go to SHIFT.
  - If 1, treat as a glitch and return to IDLE with no strobe.
- SHIFT:
  - The counter runs 1..CLKS_PER_BIT. On reaching CLKS_PER_BIT, assert shift_enable for exactly one cycle, increment the bit count and wrap the counter.
  - After DATA_BITS+1 strobes (data plus stop bit), go to STOP_CHK.
- STOP_CHK (sr_parallel now holds the whole frame):
  - If sr_parallel[DATA_BITS] == 1, go to LOAD.
  - Otherwise set framing_error, leave rx_data/data_ready unchanged, and go to IDLE.
- LOAD:
  - rx_data ← sr_parallel[DATA_BITS-1:0] and data_ready ← 1; return to IDLE.
  - If data_ready was already 1 and data_read is low in this cycle, set overrun_error. The new byte still overwrites rx_data.
- data_read = 1 clears data_ready and overrun_error on the next edge.
  - If data_read coincides with a LOAD, LOAD wins: data_ready stays 1 and no overrun is flagged.
- serial_in is ignored during SHIFT/STOP_CHK/LOAD; edges there never restart a frame.
- The controller never resets the shift register. Stale contents are harmless because every frame overwrites all DATA_BITS+1 positions.
- Counter widths: bit-period counter is clog2(CLKS_PER_BIT+1) bits; bit counter is clog2(DATA_BITS+2) bits; neither wraps outside its defined range.

## Timing
- The start edge is detected in cycle 0.
- The Nth strobe (N = 1..DATA_BITS+1) is high in cycle floor(CLKS_PER_BIT/2) + N·CLKS_PER_BIT.
- With T = cycle of the last strobe:
  - STOP_CHK is in cycle T+1.
  - LOAD is in cycle T+2.
  - rx_data, data_ready and overrun_error are valid from cycle T+3.
  - framing_error (bad stop bit) is valid from cycle T+2.
- busy is registered from state: high in cycles 1 through the last non-IDLE cycle, and low once IDLE is re-entered.
- Glitch: START_CHK samples in cycle floor(CLKS_PER_BIT/2); busy is low the following cycle.
- rst mid-frame: the next cycle matches the reset state, and any partial byte is discarded. The next start edge after rst deasserts begins a clean frame.
- Back-to-back frames: a start edge arriving in the first cycle of IDLE after LOAD is accepted.

## Test plan
CLKS_PER_BIT = 10, DATA_BITS = 8, external shift register of width 9 shifting LSB-first.
- Reset: assert rst for 2 cycles → all outputs 0, busy 0; with serial_in held high, no shift_enable over 200 cycles.
- Good frame with data 0xA5 and stop bit 1 → strobes in cycles 15, 25, …, 95; rx_data = 0xA5 and data_ready = 1 from cycle 98; framing_error = 0; busy low from cycle 98.
- Glitch: serial_in low for cycles 0–2 only → no strobe; busy high in cycles 1–5 and low in cycle 6.
- Bad stop: frame 0x3C with stop bit 0 → framing_error = 1 from cycle 97; data_ready stays 0 and rx_data is unchanged. framing_error clears on the next start edge.
- Overrun: frames 0x11 then 0x22 with no data_read → overrun_error = 1, rx_data = 0x22. A data_read pulse clears data_ready and overrun_error next cycle. Repeat with data_read asserted in the LOAD cycle → no overrun.
- Reset mid-frame: rst asserted in cycle 50 → outputs zero and busy 0 the next cycle. A subsequent frame 0x5A is then received correctly.

Source files
------------

// File: rtl/rcv_if.sv
// -----------------------------------------------------------------------------
// rcv_if
// Bundle of the receive-side signals around rcv_controller.
//
//   serial_in      synchronized serial line, idle high
//   sr_parallel    parallel view of the external LSB-first shift register;
//                  bit DATA_BITS is the stop bit, DATA_BITS-1:0 are data
//   shift_enable   one-cycle strobe to the shift register
//   data_read      consumer acknowledge of rx_data
//   rx_data        last accepted byte
//   data_ready     rx_data holds an unread byte
//   framing_error  last frame had a zero stop bit
//   overrun_error  a byte was overwritten before being read
//   busy           frame reception in progress
//
// master : the controller side (drives strobe and status)
// slave  : the surrounding line/shift-register/consumer logic
// -----------------------------------------------------------------------------
interface rcv_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_in;
  logic [DATA_BITS:0]   sr_parallel;
  logic                 shift_enable;
  logic                 data_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 busy;

  modport master (
    input  serial_in,
    input  sr_parallel,
    input  data_read,
    output shift_enable,
    output rx_data,
    output data_ready,
    output framing_error,
    output overrun_error,
    output busy
  );

  modport slave (
    output serial_in,
    output sr_parallel,
    output data_read,
    input  shift_enable,
    input  rx_data,
    input  data_ready,
    input  framing_error,
    input  overrun_error,
    input  busy
  );
endinterface

// File: rtl/rcv_controller.sv
// -----------------------------------------------------------------------------
// rcv_controller
// Receive-side sequencer for a UART-style link. Detects a start edge, confirms
// it at mid start bit, then times DATA_BITS+1 bit periods and issues one
// shift strobe per bit to an external LSB-first shift register. After the
// stop bit has been shifted in it checks the stop bit and either loads the
// byte into the output buffer or flags a framing error.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   rx_bus  rcv_if.master: serial_in, sr_parallel, data_read in;
//           shift_enable, rx_data, data_ready, framing_error,
//           overrun_error, busy out (all outputs registered)
// -----------------------------------------------------------------------------
module rcv_controller #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic   clk,
  input  logic   rst,
  rcv_if.master  rx_bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = '0;
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    SHIFT,
    STOP_CHK,
    LOAD
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;        // bit-period counter
  logic [BIT_W-1:0]     r_bit_cnt;    // strobes issued in this frame
  logic                 r_edge;       // serial_in delayed one cycle
  logic                 r_shift_en;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_data_ready;
  logic                 r_framing;
  logic                 r_overrun;
  logic                 r_busy;

  logic                 w_start_edge;

  // Falling edge on the line: previous sample high, current sample low.
  assign w_start_edge = r_edge & ~rx_bus.serial_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= CNT_ZERO;
      r_bit_cnt    <= BIT_ZERO;
      r_edge       <= 1'b1;
      r_shift_en   <= 1'b0;
      r_rx_data    <= '0;
      r_data_ready <= 1'b0;
      r_framing    <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_edge     <= rx_bus.serial_in;
      r_shift_en <= 1'b0;

      // Consumer acknowledge; the LOAD branch below overrides it when both
      // happen in the same cycle.
      if (rx_bus.data_read) begin
        r_data_ready <= 1'b0;
        r_overrun    <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_state   <= START_CHK;
            r_cnt     <= CNT_ZERO;
            r_bit_cnt <= BIT_ZERO;
            r_framing <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_busy    <= 1'b0;
          end
        end

        // Re-sample the line half a bit after the edge so a short low
        // pulse is rejected instead of starting a frame.
        START_CHK: begin
          if (r_cnt == HALF_M1) begin
            if (!rx_bus.serial_in) begin
              r_state <= SHIFT;
              r_cnt   <= CNT_ONE;
            end else begin
              r_state <= IDLE;
              r_cnt   <= CNT_ZERO;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        // The strobe register is set one count early so the strobe is high
        // in exactly the cycle the counter reads FULL.
        SHIFT: begin
          if (r_cnt == FULL_M1) begin
            r_shift_en <= 1'b1;
          end
          if (r_cnt == FULL) begin
            r_cnt     <= CNT_ONE;
            r_bit_cnt <= r_bit_cnt + BIT_ONE;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= STOP_CHK;
              r_cnt   <= CNT_ZERO;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        STOP_CHK: begin
          if (rx_bus.sr_parallel[DATA_BITS]) begin
            r_state <= LOAD;
          end else begin
            r_framing <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end
        end

        LOAD: begin
          r_rx_data    <= rx_bus.sr_parallel[DATA_BITS-1:0];
          r_data_ready <= 1'b1;
          if (r_data_ready && !rx_bus.data_read) begin
            r_overrun <= 1'b1;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_bus.shift_enable  = r_shift_en;
  assign rx_bus.rx_data       = r_rx_data;
  assign rx_bus.data_ready    = r_data_ready;
  assign rx_bus.framing_error = r_framing;
  assign rx_bus.overrun_error = r_overrun;
  assign rx_bus.busy          = r_busy;

endmodule
